// File: rtl/demux_rr_param.sv
// demux_rr_param
//   Registered 1-to-NUM_CH demultiplexer, NUM_CH = 2**LOG2_CH.
//   Each valid input word goes to exactly one channel. The channel is chosen
//   in one of two ways:
//     - Round-robin: the current pointer receives BURST consecutive valid
//       words, then the pointer advances and wraps.
//     - Addressed: addr_in picks the channel and the round-robin state is
//       frozen.
//   All outputs are registered, so an accepted word appears one cycle later.
//
// Ports
//   clk        rising-edge clock
//   reset_L    synchronous active-low reset, clears all outputs and state
//   data_in    input word (DATA_WIDTH bits)
//   valid_in   input qualifier; the word is accepted on every edge where it is 1
//   mode_sel   0 = round-robin, 1 = addressed
//   addr_in    destination channel in addressed mode
//   data_out   packed channel data; channel k is [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_out  one-hot strobe, bit k set for the cycle channel k is written
//   ptr_out    current round-robin channel pointer
//   burst_cnt  words already sent to ptr_out in the current burst
`timescale 1ns/1ps

module demux_rr_param #(
  parameter int DATA_WIDTH = 4,
  parameter int LOG2_CH    = 2,
  parameter int BURST      = 1
) (
  input  logic                                  clk,
  input  logic                                  reset_L,
  input  logic [DATA_WIDTH-1:0]                 data_in,
  input  logic                                  valid_in,
  input  logic                                  mode_sel,
  input  logic [LOG2_CH-1:0]                    addr_in,
  output logic [(1<<LOG2_CH)*DATA_WIDTH-1:0]    data_out,
  output logic [(1<<LOG2_CH)-1:0]               valid_out,
  output logic [LOG2_CH-1:0]                    ptr_out,
  output logic [7:0]                            burst_cnt
);

  localparam int         NUM_CH     = 1 << LOG2_CH;
  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

  function automatic logic [NUM_CH-1:0] onehot(input logic [LOG2_CH-1:0] idx);
    logic [NUM_CH-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // The pointer width is exactly LOG2_CH, so wrap from NUM_CH-1 to 0 comes
  // from the natural overflow of the add.
  function automatic logic [LOG2_CH-1:0] ptr_inc(input logic [LOG2_CH-1:0] p);
    return p + LOG2_CH'(1);
  endfunction

  logic [NUM_CH*DATA_WIDTH-1:0] data_p1;
  logic [NUM_CH-1:0]            vld_p1;
  logic [LOG2_CH-1:0]           ptr_p1;
  logic [7:0]                   cnt_p1;

  logic [LOG2_CH-1:0]           dest_p0;
  logic [NUM_CH-1:0]            hit_p0;

  // ---- p0: pick the destination from the inputs sampled this edge ----
  always_comb begin
    dest_p0 = mode_sel ? addr_in : ptr_p1;
    hit_p0  = valid_in ? onehot(dest_p0) : '0;
  end

  // ---- p1: registered outputs and round-robin state ----
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      data_p1 <= '0;
      vld_p1  <= '0;
      ptr_p1  <= '0;
      cnt_p1  <= '0;
    end else begin
      vld_p1 <= hit_p0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (hit_p0[k]) begin
          data_p1[k*DATA_WIDTH +: DATA_WIDTH] <= data_in;
        end
      end
      // Addressed words leave the burst position untouched, so a later
      // return to round-robin resumes exactly where it stopped.
      if (valid_in && !mode_sel) begin
        if (cnt_p1 == BURST_LAST) begin
          ptr_p1 <= ptr_inc(ptr_p1);
          cnt_p1 <= '0;
        end else begin
          cnt_p1 <= cnt_p1 + 8'd1;
        end
      end
    end
  end

  assign data_out  = data_p1;
  assign valid_out = vld_p1;
  assign ptr_out   = ptr_p1;
  assign burst_cnt = cnt_p1;

endmodule

// File: tb/tb_demux_rr_param.sv
`timescale 1ns/1ps

module tb_demux_rr_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance A: 4 channels, 4-bit words, BURST=2
  logic        a_rst_n, a_vin, a_mode;
  logic [3:0]  a_din;
  logic [1:0]  a_addr;
  logic [15:0] a_dout;
  logic [3:0]  a_vout;
  logic [1:0]  a_ptr;
  logic [7:0]  a_cnt;
  logic [29:0] a_obs;
  assign a_obs = {a_dout, a_vout, a_ptr, a_cnt};

  demux_rr_param #(.DATA_WIDTH(4), .LOG2_CH(2), .BURST(2)) dut_a (
    .clk(clk), .reset_L(a_rst_n), .data_in(a_din), .valid_in(a_vin),
    .mode_sel(a_mode), .addr_in(a_addr), .data_out(a_dout),
    .valid_out(a_vout), .ptr_out(a_ptr), .burst_cnt(a_cnt)
  );

  // Instance B: 2 channels, 8-bit words, BURST=1
  logic        b_rst_n, b_vin, b_mode;
  logic [7:0]  b_din;
  logic [0:0]  b_addr;
  logic [15:0] b_dout;
  logic [1:0]  b_vout;
  logic [0:0]  b_ptr;
  logic [7:0]  b_cnt;
  logic [26:0] b_obs;
  assign b_obs = {b_dout, b_vout, b_ptr, b_cnt};

  demux_rr_param #(.DATA_WIDTH(8), .LOG2_CH(1), .BURST(1)) dut_b (
    .clk(clk), .reset_L(b_rst_n), .data_in(b_din), .valid_in(b_vin),
    .mode_sel(b_mode), .addr_in(b_addr), .data_out(b_dout),
    .valid_out(b_vout), .ptr_out(b_ptr), .burst_cnt(b_cnt)
  );

  // Reference model for instance A: channel contents, last strobe, and the
  // number of round-robin words since reset (pointer and count follow from it).
  logic [3:0] ma_data [4];
  logic [3:0] ma_vld;
  int         ma_rr;

  function automatic logic [29:0] exp_a();
    return {ma_data[3], ma_data[2], ma_data[1], ma_data[0], ma_vld,
            2'((ma_rr / 2) % 4), 8'(ma_rr % 2)};
  endfunction

  task automatic drive_a(input logic r, input logic v, input logic [3:0] d,
                         input logic m, input logic [1:0] ad);
    int dest;
    a_rst_n = r; a_vin = v; a_din = d; a_mode = m; a_addr = ad;
    @(posedge clk);
    #1;
    if (!r) begin
      for (int i = 0; i < 4; i++) ma_data[i] = '0;
      ma_vld = '0;
      ma_rr  = 0;
    end else begin
      ma_vld = '0;
      if (v) begin
        dest = m ? int'(ad) : (ma_rr / 2) % 4;
        ma_data[dest] = d;
        ma_vld[dest]  = 1'b1;
        if (!m) ma_rr++;
      end
    end
  endtask

  task automatic drive_b(input logic r, input logic v, input logic [7:0] d);
    b_rst_n = r; b_vin = v; b_din = d; b_mode = 1'b0; b_addr = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive_a(1'b0, 1'b1, 4'hF, 1'b0, 2'd0);
      n_cmp++;
      if (a_obs !== 30'h0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h required %h", i, a_obs, 30'h0);
      end
    end
  endtask

  task automatic test_rr_wrap();
    logic [29:0] e [8];
    e = '{{16'h0001, 4'b0001, 2'd0, 8'd1}, {16'h0002, 4'b0001, 2'd1, 8'd0},
          {16'h0032, 4'b0010, 2'd1, 8'd1}, {16'h0042, 4'b0010, 2'd2, 8'd0},
          {16'h0542, 4'b0100, 2'd2, 8'd1}, {16'h0642, 4'b0100, 2'd3, 8'd0},
          {16'h7642, 4'b1000, 2'd3, 8'd1}, {16'h8642, 4'b1000, 2'd0, 8'd0}};
    for (int i = 0; i < 8; i++) begin
      drive_a(1'b1, 1'b1, 4'(i + 1), 1'b0, 2'd0);
      n_cmp++;
      if (a_obs !== e[i]) begin
        n_fail++;
        $display("FAIL rr_wrap[%0d]: got %h required %h", i, a_obs, e[i]);
      end
    end
  endtask

  task automatic test_gaps();
    logic [29:0] e [5];
    logic        v [5];
    logic [3:0]  d [5];
    v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    d = '{4'hA, 4'h5, 4'h6, 4'h7, 4'hB};
    e = '{{16'h864A, 4'b0001, 2'd0, 8'd1}, {16'h864A, 4'b0000, 2'd0, 8'd1},
          {16'h864A, 4'b0000, 2'd0, 8'd1}, {16'h864A, 4'b0000, 2'd0, 8'd1},
          {16'h864B, 4'b0001, 2'd1, 8'd0}};
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, v[i], d[i], 1'b0, 2'd0);
      n_cmp++;
      if (a_obs !== e[i]) begin
        n_fail++;
        $display("FAIL gaps[%0d]: got %h required %h", i, a_obs, e[i]);
      end
    end
  endtask

  task automatic test_addressed();
    logic [29:0] e  [4];
    logic        m  [4];
    logic [1:0]  ad [4];
    logic [3:0]  d  [4];
    m  = '{1'b0, 1'b1, 1'b1, 1'b0};
    ad = '{2'd2, 2'd3, 2'd1, 2'd2};
    d  = '{4'h3, 4'hC, 4'hD, 4'hE};
    e  = '{{16'h0003, 4'b0001, 2'd0, 8'd1}, {16'hC003, 4'b1000, 2'd0, 8'd1},
           {16'hC0D3, 4'b0010, 2'd0, 8'd1}, {16'hC0DE, 4'b0001, 2'd1, 8'd0}};
    drive_a(1'b0, 1'b0, 4'h0, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 1'b1, d[i], m[i], ad[i]);
      n_cmp++;
      if (a_obs !== e[i]) begin
        n_fail++;
        $display("FAIL addressed[%0d]: got %h required %h", i, a_obs, e[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    drive_a(1'b0, 1'b0, 4'h0, 1'b0, 2'd0);
    for (int i = 1; i <= 5; i++) drive_a(1'b1, 1'b1, 4'(i), 1'b0, 2'd0);
    n_cmp++;
    if (a_obs !== {16'h0542, 4'b0100, 2'd2, 8'd1}) begin
      n_fail++;
      $display("FAIL mid_burst_pre: got %h required %h", a_obs,
               {16'h0542, 4'b0100, 2'd2, 8'd1});
    end
    drive_a(1'b0, 1'b1, 4'h6, 1'b0, 2'd0);
    n_cmp++;
    if (a_obs !== 30'h0) begin
      n_fail++;
      $display("FAIL mid_burst_clear: got %h required %h", a_obs, 30'h0);
    end
    drive_a(1'b1, 1'b1, 4'h9, 1'b0, 2'd0);
    n_cmp++;
    if (a_obs !== {16'h0009, 4'b0001, 2'd0, 8'd1}) begin
      n_fail++;
      $display("FAIL mid_burst_after: got %h required %h", a_obs,
               {16'h0009, 4'b0001, 2'd0, 8'd1});
    end
  endtask

  task automatic test_generality();
    logic [26:0] e [3];
    logic [7:0]  d [3];
    d = '{8'h11, 8'h22, 8'h33};
    e = '{{16'h0011, 2'b01, 1'b1, 8'd0}, {16'h2211, 2'b10, 1'b0, 8'd0},
          {16'h2233, 2'b01, 1'b1, 8'd0}};
    drive_b(1'b0, 1'b1, 8'hFF);
    n_cmp++;
    if (b_obs !== 27'h0) begin
      n_fail++;
      $display("FAIL gen_reset: got %h required %h", b_obs, 27'h0);
    end
    for (int i = 0; i < 3; i++) begin
      drive_b(1'b1, 1'b1, d[i]);
      n_cmp++;
      if (b_obs !== e[i]) begin
        n_fail++;
        $display("FAIL generality[%0d]: got %h required %h", i, b_obs, e[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [29:0] e;
    drive_a(1'b0, 1'b0, 4'h0, 1'b0, 2'd0);
    for (int i = 0; i < 400; i++) begin
      drive_a(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
              4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
              2'($urandom_range(0, 3)));
      e = exp_a();
      n_cmp++;
      if (a_obs !== e) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h required %h", i, a_obs, e);
      end
    end
  endtask

  initial begin
    a_rst_n = 1'b0; a_vin = 1'b0; a_din = '0; a_mode = 1'b0; a_addr = '0;
    b_rst_n = 1'b0; b_vin = 1'b0; b_din = '0; b_mode = 1'b0; b_addr = '0;
    for (int i = 0; i < 4; i++) ma_data[i] = '0;
    ma_vld = '0;
    ma_rr  = 0;
    #2;
    test_reset();
    test_rr_wrap();
    test_gaps();
    test_addressed();
    test_reset_mid_burst();
    test_generality();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
